// File: rtl/sme_pkg.sv
// rtl/sme_pkg.sv - shared helpers for the SME masked datapath
// Share-count helpers used to size guard randomness and index share pairs.
package sme_pkg;

  localparam int SME_DEFAULT_D = 2;

  function automatic int sme_rmax(input int d);
    return d * (d - 1) / 2;
  endfunction

  // Linear index of pair (i,j), i<j, into the packed guard-word vector.
  function automatic int sme_pairidx(input int i, input int j, input int d);
    return i * d - i * (i + 1) / 2 + (j - i - 1);
  endfunction

endpackage

// File: rtl/sme_dom_and_pipe_if.sv
// rtl/sme_dom_and_pipe_if.sv - operand/randomness/result handshake bundle
// Share i of each D*W vector lives at bits [i*W +: W].
interface sme_dom_and_pipe_if
  import sme_pkg::*;
#(
  parameter int D = 2,
  parameter int W = 32
);

  localparam int RMAX = sme_rmax(D);

  logic              in_valid;
  logic              in_ready;
  logic [D*W-1:0]    rs1;
  logic [D*W-1:0]    rs2;
  logic [RMAX*W-1:0] rng;
  logic              rng_valid;
  logic              rng_ready;
  logic              out_valid;
  logic              out_ready;
  logic [D*W-1:0]    rd;

  modport master (
    output in_valid, rs1, rs2, rng, rng_valid, out_ready,
    input  in_ready, rng_ready, out_valid, rd
  );

  modport slave (
    input  in_valid, rs1, rs2, rng, rng_valid, out_ready,
    output in_ready, rng_ready, out_valid, rd
  );

endinterface

// File: rtl/sme_dom_and_term.sv
// rtl/sme_dom_and_term.sv - one registered DOM AND partial product
// Each term is its own flop so no cross-domain combination happens before the register.
module sme_dom_and_term #(
  parameter int W = 32
) (
  input  logic         g_clk,
  input  logic         g_resetn,
  input  logic         en,
  input  logic         flush,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] z,
  output logic [W-1:0] t
);

  (* keep = "true" *) logic [W-1:0] t_q;

  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      t_q <= '0;
    end else if (flush) begin
      t_q <= '0;
    end else if (en) begin
      t_q <= (a & b) ^ z;
    end
  end

  assign t = t_q;

endmodule

// File: rtl/sme_dom_and_pipe.sv
// rtl/sme_dom_and_pipe.sv - two-stage D-share DOM AND with valid/ready handshakes
// Stage 1 registers D*D guarded terms; stage 2 compresses each domain's row into rd.
module sme_dom_and_pipe
  import sme_pkg::*;
#(
  parameter int D = SME_DEFAULT_D,
  parameter int W = 32
) (
  input  logic g_clk,
  input  logic g_resetn,
  input  logic flush,
  sme_dom_and_pipe_if.slave bus
);

  logic           s1_valid;
  logic           out_valid_q;
  logic           advance;
  logic           in_ready;
  logic           in_fire;
  logic [W-1:0]   t [D][D];
  logic [D*W-1:0] rd_q;
  logic [D*W-1:0] rd_d;

  assign advance  = !out_valid_q | bus.out_ready;
  assign in_ready = !flush & (!s1_valid | advance);
  assign in_fire  = bus.in_valid & bus.rng_valid & in_ready;

  genvar gi, gj;
  generate
    for (gi = 0; gi < D; gi++) begin : g_row
      for (gj = 0; gj < D; gj++) begin : g_col
        logic [W-1:0] z;
        if (gi == gj) begin : g_inner
          assign z = '0;
        end else begin : g_cross
          localparam int LO = (gi < gj) ? gi : gj;
          localparam int HI = (gi < gj) ? gj : gi;
          localparam int K  = sme_pairidx(LO, HI, D);
          assign z = bus.rng[K*W +: W];
        end

        sme_dom_and_term #(.W(W)) u_term (
          .g_clk    (g_clk),
          .g_resetn (g_resetn),
          .en       (in_fire),
          .flush    (flush),
          .a        (bus.rs1[gi*W +: W]),
          .b        (bus.rs2[gj*W +: W]),
          .z        (z),
          .t        (t[gi][gj])
        );
      end
    end
  endgenerate

  // Cross-domain XOR only ever sees registered terms.
  always_comb begin
    rd_d = '0;
    for (int i = 0; i < D; i++) begin
      for (int j = 0; j < D; j++) begin
        rd_d[i*W +: W] = rd_d[i*W +: W] ^ t[i][j];
      end
    end
  end

  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      s1_valid    <= 1'b0;
      out_valid_q <= 1'b0;
      rd_q        <= '0;
    end else if (flush) begin
      s1_valid    <= 1'b0;
      out_valid_q <= 1'b0;
      rd_q        <= '0;
    end else begin
      if (in_fire) begin
        s1_valid <= 1'b1;
      end else if (advance) begin
        s1_valid <= 1'b0;
      end

      if (s1_valid & advance) begin
        out_valid_q <= 1'b1;
        rd_q        <= rd_d;
      end else if (bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.rng_ready = in_fire;
  assign bus.out_valid = out_valid_q;
  assign bus.rd        = rd_q;

endmodule

// File: doc/sme_dom_and_pipe.md
Name: sme_dom_and_pipe

Overview:
- Parametrised D-share, W-bit-wide domain-oriented-masking (DOM) AND unit, pipelined over two register stages.
- Adds valid/ready handshakes on input and output, a randomness-valid qualifier and a synchronous flush.
- Sits in the SME datapath between the share-split operand registers and the masked ALU result mux.
- Fixed-D variants are wrapped separately for SILVER leakage checking.

Parameters:
- D, 2, number of shares (>=2)
- W, 32, bit width of each share
- RMAX, D*(D-1)/2, derived local: number of fresh guard words per operation

Ports:
- g_clk  in  1  single clock; all state on posedge
- g_resetn  in  1  asynchronous active-low reset
- flush  in  1  synchronous pipeline clear
- in_valid  in  1  operands presented
- in_ready  out  1  unit can accept operands this cycle
- rs1  in  D*W  operand A; share i at bits [i*W +: W]
- rs2  in  D*W  operand B; same share layout as rs1
- rng  in  RMAX*W  fresh randomness; guard word k at bits [k*W +: W]
- rng_valid  in  1  rng is fresh this cycle
- rng_ready  out  1  rng consumed this cycle (equals in_fire)
- out_valid  out  1  rd holds a result
- out_ready  in  1  consumer accepts rd
- rd  out  D*W  result shares; XOR of all shares equals (XOR rs1) AND (XOR rs2)

Behaviour:
- Reset (async assert, release sync to g_clk): all data registers 0; s1_valid=0; out_valid=0; rd=0. After reset, in_ready=1.
- advance = !out_valid | out_ready.
- in_ready = !flush & (!s1_valid | advance).
- in_fire = in_valid & rng_valid & in_ready. Randomness is never reused; an op with rng_valid=0 stalls, and no share data is captured.
- Stage 1 loads on in_fire. For each share pair (i,j), one register word t[i][j]:
  - i==j: a_i & b_i. The inner-domain term is registered too, to keep domains aligned.
  - i!=j: (a_i & b_j) ^ z_k, where k = pairidx(min(i,j), max(i,j)).
  - pairidx(i,j) = i*D - i*(i+1)/2 + (j-i-1). For D=3: (0,1)->0, (0,2)->1, (1,2)->2.
- Stage 1 terms must be distinct flops. Synthesis must not merge, share or retime them (glitch security). Cross-domain XOR happens only after the register.
- Stage 2 loads on s1_valid & advance: rd_i <= XOR over j of t[i][j].
- s1_valid next value:
  - in_fire -> 1
  - else if advance -> 0
  - else hold
- out_valid next value:
  - s1_valid & advance -> 1
  - else if out_ready -> 0
  - else hold
- Latency: 2 cycles from in_fire edge to out_valid=1. Throughput is 1 op/cycle when out_ready is held high.
- Stall (out_valid & !out_ready): rd and t hold stable. in_ready falls once s1_valid=1. No op is dropped or duplicated.
- Simultaneous in_fire and stage 2 drain in the same cycle: both happen. Stage 1 takes the new op, rd takes the old one.
- flush=1 at a posedge:
  - s1_valid, out_valid, every t word and rd <= 0.
  - in_ready=0 for that cycle, so nothing is accepted.
  - flush overrides all other updates.
- Async reset mid-operation: everything clears immediately. The in-flight op is lost and no out_valid is generated for it.
- Data registers update only on their load enables, which minimises toggling of share data.

Decomposition:
- Package sme_pkg holds:
  - function sme_rmax(D)
  - function sme_pairidx(i,j,D)
  - localparam SME_DEFAULT_D
- Sub-module sme_dom_and_term (W-bit): computes and registers one (i,j) term with its enable and flush. Generate loops instantiate D*D of them.
- The top level holds the handshake control and the stage 2 XOR-compress register.

Test Plan:
- Basic, D=2, W=8. rs1 shares {0xAA,0x5A} (value 0xF0), rs2 shares {0x2D,0x11} (value 0x3C), rng=0x77, in_valid=rng_valid=out_ready=1 for one cycle -> out_valid=1 exactly 2 cycles later; rd share0^share1 = 0x30.
- Randomness dependence: repeat the basic op with rng=0x00, then rng=0xFF -> XOR of rd stays 0x30; individual rd shares differ between the two runs.
- Backpressure: stream 4 ops with out_ready=0 from cycle 3 to cycle 8 -> in_ready drops after the 2nd op is accepted; all 4 results appear in order with no loss or duplication; rd is stable while stalled.
- rng starvation: in_valid=1, rng_valid=0 for 3 cycles -> rng_ready=0, no stage 1 load, out_valid stays 0; rng_valid=1 in the 4th cycle -> op accepted.
- Flush: flush=1 with s1_valid=1 and out_valid=1 -> next cycle both valids are 0, rd=0, and the dropped ops never emerge.
- D=3, W=32, random operands over 1000 ops with random handshakes -> XOR of 3 result shares == AND of unmasked operands; async reset asserted mid-stream -> all outputs 0 immediately.
